// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, write strobes and
// packed write data in; one-hot grant, register contents and status out.
interface rr_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         wr_en;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic [WIDTH-1:0]   q;
    logic [1:0]         owner;
    logic               busy;
    logic               timeout;

    modport master (
        output req, wr_en, wdata,
        input  gnt, q, owner, busy, timeout
    );

    modport slave (
        input  req, wr_en, wdata,
        output gnt, q, owner, busy, timeout
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin owner of a shared register among 4 requesters; grant one cycle after request.
// Tenure ends on request drop or after HOLD_MAX cycles, followed by one turnaround cycle.
module rr_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_reg_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       sel;
    logic             found;
    logic [1:0]       idx;

    // Descending scan so the candidate closest to ptr is the last one assigned.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        q_d        = q_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (found) begin
                    owner_d    = sel;
                    gnt_d      = 4'b0001 << sel;
                    hold_cnt_d = 8'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                end else begin
                    if (bus.wr_en[owner_q]) begin
                        q_d = bus.wdata[owner_q*WIDTH +: WIDTH];
                    end
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    // The last permitted cycle still takes its write before the forced handover.
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d   = RELEASE;
                        gnt_d     = 4'b0000;
                        ptr_d     = owner_q + 2'd1;
                        timeout_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == GRANT) || (state_d == RELEASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'b0000;
            q_q        <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: one instance with HOLD_MAX=4, one with HOLD_MAX=1.
module tb_rr_reg_arbiter;
    localparam int HM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_reg_arbiter_if #(.WIDTH(8)) ifa ();
    rr_reg_arbiter_if #(.WIDTH(8)) ifb ();

    rr_reg_arbiter #(.WIDTH(8), .HOLD_MAX(HM)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rr_reg_arbiter #(.WIDTH(8), .HOLD_MAX(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr_en;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
        logic        timeout;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] r, logic [3:0] w, logic [31:0] d,
                                logic [3:0] g, logic [7:0] qq, logic [1:0] o,
                                logic b, logic t);
        vec_t v;
        v.req = r; v.wr_en = w; v.wdata = d;
        v.gnt = g; v.q = qq; v.owner = o; v.busy = b; v.timeout = t;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    task automatic step(input vec_t v, input bit use_b, input string tag, input int idx);
        vec_t e;
        logic [3:0] g;
        logic [7:0] qv;
        logic [1:0] o;
        logic b, t;
        @(negedge clk);
        if (use_b) begin
            ifb.req = v.req; ifb.wr_en = v.wr_en; ifb.wdata = v.wdata;
            ifa.req = '0;    ifa.wr_en = '0;      ifa.wdata = '0;
        end else begin
            ifa.req = v.req; ifa.wr_en = v.wr_en; ifa.wdata = v.wdata;
            ifb.req = '0;    ifb.wr_en = '0;      ifb.wdata = '0;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (use_b) begin
            g = ifb.gnt; qv = ifb.q; o = ifb.owner; b = ifb.busy; t = ifb.timeout;
        end else begin
            g = ifa.gnt; qv = ifa.q; o = ifa.owner; b = ifa.busy; t = ifa.timeout;
        end
        chk($sformatf("%s[%0d].gnt", tag, idx),     32'(g),  32'(e.gnt));
        chk($sformatf("%s[%0d].q", tag, idx),       32'(qv), 32'(e.q));
        chk($sformatf("%s[%0d].owner", tag, idx),   32'(o),  32'(e.owner));
        chk($sformatf("%s[%0d].busy", tag, idx),    32'(b),  32'(e.busy));
        chk($sformatf("%s[%0d].timeout", tag, idx), 32'(t),  32'(e.timeout));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".a.gnt"},     32'(ifa.gnt),     32'd0);
        chk({tag, ".a.q"},       32'(ifa.q),       32'd0);
        chk({tag, ".a.owner"},   32'(ifa.owner),   32'd0);
        chk({tag, ".a.busy"},    32'(ifa.busy),    32'd0);
        chk({tag, ".a.timeout"}, 32'(ifa.timeout), 32'd0);
        chk({tag, ".b.gnt"},     32'(ifb.gnt),     32'd0);
        chk({tag, ".b.q"},       32'(ifb.q),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] qb;
        logic [3:0] oh;
        int g;

        ifa.req = '0; ifa.wr_en = '0; ifa.wdata = '0;
        ifb.req = '0; ifb.wr_en = '0; ifb.wdata = '0;

        // Release of owner 0 while requester 3 waits, then single grant, then non-owner strobes.
        tbl.push_back(mk(4'b1001, 4'b0000, 32'h0,        4'b0001, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1001, 4'b0000, 32'h0,        4'b0001, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1001, 4'b0000, 32'h0,        4'b0001, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1001, 4'b0000, 32'h0,        4'b0001, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h0,        4'b0000, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h0,        4'b0000, 8'h00, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h0,        4'b1000, 8'h00, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 8'h00, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 8'h00, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0100, 4'b0000, 32'h0,        4'b0100, 8'h00, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0100, 4'b0100, 32'h00A50000, 4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 8'hA5, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 8'hA5, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b0000, 32'h0,        4'b0010, 8'hA5, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b1101, 32'h44332211, 4'b0010, 8'hA5, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b1111, 32'h44332211, 4'b0010, 8'h22, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b0000, 32'h0,        4'b0010, 8'h22, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b0010, 32'h00007700, 4'b0000, 8'h77, 2'd1, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 8'h77, 2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0000, 32'h0,        4'b0001, 8'h77, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 2'd0, 1'b1, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, "tbl", i);

        // Asynchronous reset while owner 0 holds the register at 8'h5A.
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        ifa.req = '0; ifa.wr_en = '0; ifa.wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full contention: grants 0,1,2,3,0, HM cycles each, two low cycles between.
        for (int t = 0; t < 5; t++) begin
            oh = 4'(1 << (t % 4));
            for (int e = 0; e <= HM + 1; e++) begin
                step(mk(4'b1111, 4'b0000, 32'h0,
                        (e < HM) ? oh : 4'b0000, 8'h00, 2'(t % 4),
                        (e <= HM), (e == HM)),
                     1'b0, $sformatf("contend_t%0d", t), e);
            end
        end

        // HOLD_MAX=1: one write per tenure, strobes outside GRANT ignored.
        qb = 8'h00;
        g = 0;
        for (int t = 0; t < 3; t++) begin
            for (int e = 0; e < 3; e++) begin
                if (e == 1) qb = 8'(8'h30 + g);
                step(mk(4'b0010, 4'b0010, {16'h0, 8'(8'h30 + g), 8'h00},
                        (e == 0) ? 4'b0010 : 4'b0000, qb, 2'd1,
                        (e <= 1), (e == 1)),
                     1'b1, $sformatf("hold1_t%0d", t), e);
                g++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
